rat_recovery_ctrl: RTL and testbench
====================================

RAT_RECOVERY_CTRL -- requirements
Module: rat_recovery_ctrl

Interface
REQ-001 SHALL have parameter ROB_IDX_WIDTH, default 6, giving ROB entry index width; ROB depth is 2^ROB_IDX_WIDTH (64).
REQ-002 SHALL have one clock and asynchronous active-low reset; ports listed below, clock and reset first.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 flush_valid  in  1  mispredict/exception flush request.
REQ-006 flush_robid  in  7  ROB id of the flushing instruction, including wrap bit [6].
REQ-007 rob_head  in  7  oldest uncommitted ROB id, including wrap bit.
REQ-008 flush_ready  out  1  flush accepted this cycle when high; equals is_idle.
REQ-009 walk2rob_rdaddr0, walk2rob_rdaddr1  out  6 each  ROB read addresses for walk slots 0/1.
REQ-010 rob2walk_lrd0/1  in  5 each; rob2walk_prd0/1  in  6 each; rob2walk_need_to_wb0/1  in  1 each  ROB read data, combinational same cycle.
REQ-011 is_idle, is_rollingback, is_walking  out  1 each  one-hot state to spec RAT.
REQ-012 walking_valid0/1  out  1 each; walking_lrd0/1  out  5 each; walking_prd0/1  out  6 each  walk write ports to spec RAT.
REQ-013 walk_done  out  1  one-cycle pulse on WALK->IDLE.
REQ-014 rename_stall, commit_stall  out  1 each  high whenever not IDLE.

Function
REQ-015 SHALL implement FSM IDLE, ROLLBACK, WALK; is_* outputs registered, exactly one high.
REQ-016 IDLE->ROLLBACK when flush_valid in IDLE; SHALL latch walk_ptr=rob_head and walk_end=flush_robid+1 (7-bit, mod 128).
REQ-017 flush_valid outside IDLE SHALL be ignored (no latch, no state change).
REQ-018 ROLLBACK SHALL last exactly one cycle, then enter WALK; remaining=walk_end-walk_ptr (7-bit mod 128), always 1..64.
REQ-019 In WALK, rdaddr0=walk_ptr[5:0], rdaddr1=(walk_ptr+1)[5:0], wrapping 63->0.
REQ-020 walking_valid0 = is_walking & (remaining>=1) & rob2walk_need_to_wb0.
REQ-021 walking_valid1 = is_walking & (remaining>=2) & rob2walk_need_to_wb1.
REQ-022 walking_lrd/prd SHALL pass ROB read data straight through; SHALL be 0 when corresponding valid low.
REQ-023 Each WALK cycle walk_ptr advances by min(2, remaining); remaining decrements likewise.
REQ-024 When remaining<=2 at a WALK cycle, next state IDLE and walk_done=1 that next cycle... walk_done asserted in the first IDLE cycle only.
REQ-025 WALK duration SHALL be ceil(N/2) cycles for N=remaining; total flush-to-idle latency 2+ceil(N/2) cycles.
REQ-026 Entries with need_to_wb=0 SHALL still consume walk slots (no compaction).
REQ-027 Same-lrd conflict between slot 0 and slot 1 is resolved by spec RAT (slot 1 wins); block SHALL NOT suppress either valid.
REQ-028 rdaddr outputs in IDLE/ROLLBACK SHALL be 0; walking_valid* SHALL be 0 outside WALK.
REQ-029 rename_stall and commit_stall SHALL be combinationally equal to ~is_idle.

Reset
REQ-030 reset_n low SHALL force IDLE immediately: is_idle=1, others 0, walk_ptr=0, walk_end=0, remaining=0, walk_done=0, all walking_* and rdaddr = 0.
REQ-031 Reset mid-ROLLBACK or mid-WALK SHALL abandon the walk; no walk_done pulse on release.
REQ-032 First flush after reset release SHALL be accepted on the first clock edge with flush_valid high.

Verification
REQ-033 rob_head=7'd10, flush_robid=7'd14 -> ROLLBACK 1 cycle, WALK 3 cycles reading (10,11),(12,13),(14,-) with valid1=0 in last, walk_done cycle 6.
REQ-034 rob_head=7'd62, flush_robid=7'd65 (wrap) -> rdaddr pairs (62,63),(0,1), N=4, WALK 2 cycles.
REQ-035 N=1 (flush_robid=rob_head) -> one WALK cycle, only slot 0 eligible, walk_done next cycle.
REQ-036 need_to_wb0=0, need_to_wb1=1 in a WALK cycle -> walking_valid0=0, lrd0/prd0=0, valid1=1, pointer still advances by 2.
REQ-037 flush_valid held high during WALK with different flush_robid -> ignored; walk end unchanged; flush_ready=0 throughout.
REQ-038 reset_n asserted in second WALK cycle -> is_idle=1 same cycle asynchronously, stalls low, no walk_done after release.

Source files
------------

// File: rtl/rat_recovery_ctrl.sv
// rtl/rat_recovery_ctrl.sv - rename-table recovery controller: flush rollback then ROB walk
module rat_recovery_ctrl #(
    parameter int ROB_IDX_WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush_valid,
    input  logic [ROB_IDX_WIDTH:0]   flush_robid,
    input  logic [ROB_IDX_WIDTH:0]   rob_head,
    output logic                     flush_ready,
    output logic [ROB_IDX_WIDTH-1:0] walk2rob_rdaddr0,
    output logic [ROB_IDX_WIDTH-1:0] walk2rob_rdaddr1,
    input  logic [4:0]               rob2walk_lrd0,
    input  logic [4:0]               rob2walk_lrd1,
    input  logic [5:0]               rob2walk_prd0,
    input  logic [5:0]               rob2walk_prd1,
    input  logic                     rob2walk_need_to_wb0,
    input  logic                     rob2walk_need_to_wb1,
    output logic                     is_idle,
    output logic                     is_rollingback,
    output logic                     is_walking,
    output logic                     walking_valid0,
    output logic                     walking_valid1,
    output logic [4:0]               walking_lrd0,
    output logic [4:0]               walking_lrd1,
    output logic [5:0]               walking_prd0,
    output logic [5:0]               walking_prd1,
    output logic                     walk_done,
    output logic                     rename_stall,
    output logic                     commit_stall
);

    localparam int ID_W = ROB_IDX_WIDTH + 1;

    // One-hot encoding so the is_* outputs come straight from state flops.
    typedef enum logic [2:0] {
        S_IDLE     = 3'b001,
        S_ROLLBACK = 3'b010,
        S_WALK     = 3'b100
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   walk_ptr;
    logic [ID_W-1:0]   walk_end;
    logic [ID_W-1:0]   remaining;
    logic [ID_W-1:0]   walk_step;
    logic [ID_W-1:0]   walk_ptr_p1;
    logic              last_walk;

    assign is_idle        = state_q[0];
    assign is_rollingback = state_q[1];
    assign is_walking     = state_q[2];

    assign flush_ready  = is_idle;
    assign rename_stall = ~is_idle;
    assign commit_stall = ~is_idle;

    // Two slots per cycle, except a lone final entry takes one.
    assign walk_step   = (remaining >= ID_W'(2)) ? ID_W'(2) : ID_W'(1);
    assign last_walk   = (remaining <= ID_W'(2));
    assign walk_ptr_p1 = walk_ptr + ID_W'(1);

    // Next-state selection; flushes outside IDLE are simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (flush_valid) state_d = S_ROLLBACK;
            S_ROLLBACK: state_d = S_WALK;
            S_WALK:     if (last_walk) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State register and walk bookkeeping; reset abandons any walk in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            walk_ptr  <= '0;
            walk_end  <= '0;
            remaining <= '0;
            walk_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            walk_done <= (state_q == S_WALK) && last_walk;
            case (state_q)
                S_IDLE: begin
                    if (flush_valid) begin
                        walk_ptr <= rob_head;
                        walk_end <= flush_robid + ID_W'(1);
                    end
                end
                S_ROLLBACK: begin
                    remaining <= walk_end - walk_ptr;
                end
                S_WALK: begin
                    walk_ptr  <= walk_ptr + walk_step;
                    remaining <= remaining - walk_step;
                end
                default: ;
            endcase
        end
    end

    // ROB read addresses and walk write ports; zeroed whenever not walking.
    always_comb begin
        walk2rob_rdaddr0 = '0;
        walk2rob_rdaddr1 = '0;
        walking_valid0   = 1'b0;
        walking_valid1   = 1'b0;
        walking_lrd0     = '0;
        walking_lrd1     = '0;
        walking_prd0     = '0;
        walking_prd1     = '0;
        if (is_walking) begin
            walk2rob_rdaddr0 = walk_ptr[ROB_IDX_WIDTH-1:0];
            walk2rob_rdaddr1 = walk_ptr_p1[ROB_IDX_WIDTH-1:0];
            walking_valid0   = (remaining >= ID_W'(1)) && rob2walk_need_to_wb0;
            walking_valid1   = (remaining >= ID_W'(2)) && rob2walk_need_to_wb1;
        end
        if (walking_valid0) begin
            walking_lrd0 = rob2walk_lrd0;
            walking_prd0 = rob2walk_prd0;
        end
        if (walking_valid1) begin
            walking_lrd1 = rob2walk_lrd1;
            walking_prd1 = rob2walk_prd1;
        end
    end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// tb/tb_rat_recovery_ctrl.sv - directed bench for rat_recovery_ctrl
module tb_rat_recovery_ctrl;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       flush_valid;
    logic [6:0] flush_robid;
    logic [6:0] rob_head;
    logic       flush_ready;
    logic [5:0] walk2rob_rdaddr0, walk2rob_rdaddr1;
    logic [4:0] rob2walk_lrd0, rob2walk_lrd1;
    logic [5:0] rob2walk_prd0, rob2walk_prd1;
    logic       rob2walk_need_to_wb0, rob2walk_need_to_wb1;
    logic       is_idle, is_rollingback, is_walking;
    logic       walking_valid0, walking_valid1;
    logic [4:0] walking_lrd0, walking_lrd1;
    logic [5:0] walking_prd0, walking_prd1;
    logic       walk_done, rename_stall, commit_stall;

    logic [63:0] nwb_mask;
    int checks = 0;
    int errors = 0;

    rat_recovery_ctrl #(.ROB_IDX_WIDTH(6)) dut (
        .clock(clock), .reset_n(reset_n),
        .flush_valid(flush_valid), .flush_robid(flush_robid), .rob_head(rob_head),
        .flush_ready(flush_ready),
        .walk2rob_rdaddr0(walk2rob_rdaddr0), .walk2rob_rdaddr1(walk2rob_rdaddr1),
        .rob2walk_lrd0(rob2walk_lrd0), .rob2walk_lrd1(rob2walk_lrd1),
        .rob2walk_prd0(rob2walk_prd0), .rob2walk_prd1(rob2walk_prd1),
        .rob2walk_need_to_wb0(rob2walk_need_to_wb0), .rob2walk_need_to_wb1(rob2walk_need_to_wb1),
        .is_idle(is_idle), .is_rollingback(is_rollingback), .is_walking(is_walking),
        .walking_valid0(walking_valid0), .walking_valid1(walking_valid1),
        .walking_lrd0(walking_lrd0), .walking_lrd1(walking_lrd1),
        .walking_prd0(walking_prd0), .walking_prd1(walking_prd1),
        .walk_done(walk_done), .rename_stall(rename_stall), .commit_stall(commit_stall)
    );

    always #5 clock = ~clock;

    // ROB storage model: contents derived from the address, need_to_wb from a mask.
    always_comb begin
        rob2walk_lrd0        = walk2rob_rdaddr0[4:0] + 5'd3;
        rob2walk_lrd1        = walk2rob_rdaddr1[4:0] + 5'd3;
        rob2walk_prd0        = walk2rob_rdaddr0 ^ 6'h2a;
        rob2walk_prd1        = walk2rob_rdaddr1 ^ 6'h2a;
        rob2walk_need_to_wb0 = nwb_mask[walk2rob_rdaddr0];
        rob2walk_need_to_wb1 = nwb_mask[walk2rob_rdaddr1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic done);
        chk({tag, "_state"}, {29'd0, is_idle, is_rollingback, is_walking}, 32'b100);
        chk({tag, "_done"}, {31'd0, walk_done}, {31'd0, done});
        chk({tag, "_ready"}, {31'd0, flush_ready}, 32'd1);
        chk({tag, "_stall"}, {30'd0, rename_stall, commit_stall}, 32'd0);
        chk({tag, "_addr"}, {20'd0, walk2rob_rdaddr0, walk2rob_rdaddr1}, 32'd0);
        chk({tag, "_wv"}, {30'd0, walking_valid0, walking_valid1}, 32'd0);
    endtask

    task automatic chk_rb(input string tag);
        chk({tag, "_state"}, {29'd0, is_idle, is_rollingback, is_walking}, 32'b010);
        chk({tag, "_ready"}, {31'd0, flush_ready}, 32'd0);
        chk({tag, "_stall"}, {30'd0, rename_stall, commit_stall}, 32'b11);
        chk({tag, "_addr"}, {20'd0, walk2rob_rdaddr0, walk2rob_rdaddr1}, 32'd0);
        chk({tag, "_wv"}, {30'd0, walking_valid0, walking_valid1}, 32'd0);
    endtask

    task automatic chk_walk(input string tag, input logic [5:0] a0, input logic [5:0] a1,
                            input logic v0, input logic v1);
        logic [4:0] l0, l1;
        logic [5:0] p0, p1;
        l0 = v0 ? a0[4:0] + 5'd3 : 5'd0;
        l1 = v1 ? a1[4:0] + 5'd3 : 5'd0;
        p0 = v0 ? a0 ^ 6'h2a : 6'd0;
        p1 = v1 ? a1 ^ 6'h2a : 6'd0;
        chk({tag, "_state"}, {29'd0, is_idle, is_rollingback, is_walking}, 32'b001);
        chk({tag, "_ready"}, {31'd0, flush_ready}, 32'd0);
        chk({tag, "_stall"}, {30'd0, rename_stall, commit_stall}, 32'b11);
        chk({tag, "_done"}, {31'd0, walk_done}, 32'd0);
        chk({tag, "_addr"}, {20'd0, walk2rob_rdaddr0, walk2rob_rdaddr1}, {20'd0, a0, a1});
        chk({tag, "_wv"}, {30'd0, walking_valid0, walking_valid1}, {30'd0, v0, v1});
        chk({tag, "_d0"}, {21'd0, walking_lrd0, walking_prd0}, {21'd0, l0, p0});
        chk({tag, "_d1"}, {21'd0, walking_lrd1, walking_prd1}, {21'd0, l1, p1});
    endtask

    initial begin
        reset_n     = 1'b0;
        flush_valid = 1'b0;
        flush_robid = 7'd0;
        rob_head    = 7'd0;
        nwb_mask    = '1;
        #12;
        chk_idle("reset", 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic walk of five entries, accepted on the first edge after reset.
        flush_valid = 1'b1; rob_head = 7'd10; flush_robid = 7'd14;
        tick(); chk_rb("b_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("b_w1", 6'd10, 6'd11, 1'b1, 1'b1);
        tick(); chk_walk("b_w2", 6'd12, 6'd13, 1'b1, 1'b1);
        tick(); chk_walk("b_w3", 6'd14, 6'd15, 1'b1, 1'b0);
        tick(); chk_idle("b_done", 1'b1);
        tick(); chk_idle("b_after", 1'b0);

        // Wrap across the end of the ROB.
        flush_valid = 1'b1; rob_head = 7'd62; flush_robid = 7'd65;
        tick(); chk_rb("wr_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("wr_w1", 6'd62, 6'd63, 1'b1, 1'b1);
        tick(); chk_walk("wr_w2", 6'd0, 6'd1, 1'b1, 1'b1);
        tick(); chk_idle("wr_done", 1'b1);

        // Single-entry walk.
        flush_valid = 1'b1; rob_head = 7'd20; flush_robid = 7'd20;
        tick(); chk_rb("n1_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("n1_w1", 6'd20, 6'd21, 1'b1, 1'b0);
        tick(); chk_idle("n1_done", 1'b1);

        // Entry without writeback still occupies its slot.
        nwb_mask = '1; nwb_mask[30] = 1'b0;
        flush_valid = 1'b1; rob_head = 7'd30; flush_robid = 7'd33;
        tick(); chk_rb("nw_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("nw_w1", 6'd30, 6'd31, 1'b0, 1'b1);
        tick(); chk_walk("nw_w2", 6'd32, 6'd33, 1'b1, 1'b1);
        tick(); chk_idle("nw_done", 1'b1);
        nwb_mask = '1;

        // Flush requests while busy are ignored.
        flush_valid = 1'b1; rob_head = 7'd40; flush_robid = 7'd45;
        tick(); chk_rb("ig_rb");
        flush_robid = 7'd50; rob_head = 7'd0;
        tick(); chk_walk("ig_w1", 6'd40, 6'd41, 1'b1, 1'b1);
        tick(); chk_walk("ig_w2", 6'd42, 6'd43, 1'b1, 1'b1);
        tick(); chk_walk("ig_w3", 6'd44, 6'd45, 1'b1, 1'b1);
        tick(); chk_idle("ig_done", 1'b1);
        flush_valid = 1'b0;
        tick(); chk_idle("ig_after", 1'b0);

        // Asynchronous reset in the second walk cycle.
        flush_valid = 1'b1; rob_head = 7'd0; flush_robid = 7'd7;
        tick(); chk_rb("rs_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("rs_w1", 6'd0, 6'd1, 1'b1, 1'b1);
        tick(); chk_walk("rs_w2", 6'd2, 6'd3, 1'b1, 1'b1);
        #1 reset_n = 1'b0;
        #1 chk_idle("rs_async", 1'b0);
        tick();
        reset_n = 1'b1;
        tick(); chk_idle("rs_rel1", 1'b0);
        tick(); chk_idle("rs_rel2", 1'b0);

        // Flush accepted immediately after reset release.
        flush_valid = 1'b1; rob_head = 7'd5; flush_robid = 7'd5;
        tick(); chk_rb("pr_rb");
        flush_valid = 1'b0;
        tick(); chk_walk("pr_w1", 6'd5, 6'd6, 1'b1, 1'b0);
        tick(); chk_idle("pr_done", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
